// File: rtl/uart_tx.sv
// uart_tx: serialises one PAYLOAD_BITS-wide word per request into a
// start / data (LSB first) / stop frame. The bit timing matches the link's
// receiver, CYCLES_PER_BIT clocks per serial bit.
//
//   state | meaning
//   IDLE  | line high, waiting for uart_tx_en
//   START | start bit (line low) for one bit period
//   SEND  | data bits, LSB first, one bit period each
//   STOP  | stop bit(s), line high, STOP_BITS bit periods
module uart_tx #(
    parameter int CYCLES_PER_BIT = 5000,
    parameter int PAYLOAD_BITS   = 8,
    parameter int STOP_BITS      = 1,
    parameter int COUNT_REG_LEN  = 14
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    uart_txd,
    output logic                    uart_tx_busy
);

    localparam int BIT_CNT_W  = $clog2(PAYLOAD_BITS + 1);
    localparam int STOP_CNT_W = $clog2(STOP_BITS + 1);

    localparam logic [COUNT_REG_LEN-1:0] CYCLE_LAST = COUNT_REG_LEN'(CYCLES_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0]     BIT_LAST   = BIT_CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [STOP_CNT_W-1:0]    STOP_LAST  = STOP_CNT_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [COUNT_REG_LEN-1:0]  cycle_q, cycle_d;
    logic [BIT_CNT_W-1:0]      bit_q, bit_d;
    logic [STOP_CNT_W-1:0]     stop_q, stop_d;
    logic [PAYLOAD_BITS-1:0]   shift_q, shift_d;
    logic                      txd_q, txd_d;
    logic                      bit_end;

    assign bit_end      = (cycle_q == CYCLE_LAST);
    assign uart_txd     = txd_q;
    assign uart_tx_busy = (state_q != IDLE);

    // State, counters, shift register and the registered line driver.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cycle_q <= '0;
            bit_q   <= '0;
            stop_q  <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    // Next-state, counter updates, and the line level for the next cycle
    // (computed from the next state so the start bit appears on the
    // accepting edge itself).
    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        txd_d   = 1'b1;

        case (state_q)
            IDLE: begin
                cycle_d = '0;
                bit_d   = '0;
                stop_d  = '0;
                if (uart_tx_en) begin
                    shift_d = uart_tx_data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cycle_d = '0;
                    bit_d   = '0;
                    state_d = SEND;
                end else begin
                    cycle_d = cycle_q + 1'b1;
                end
            end
            SEND: begin
                if (bit_end) begin
                    cycle_d = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cycle_d = cycle_q + 1'b1;
                end
            end
            STOP: begin
                bit_d = '0;
                if (bit_end) begin
                    cycle_d = '0;
                    if (stop_q == STOP_LAST) begin
                        stop_d  = '0;
                        state_d = IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end else begin
                    cycle_d = cycle_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   txd_d = 1'b0;
            SEND:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives directed and random requests into uart_tx and checks
// the serial line two ways: a per-cycle frame-timing model of the expected
// line level and busy flag, and a bit-centre sampling receiver whose
// decoded bytes are matched against a queue of accepted bytes.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int PB    = 8;
    localparam int SB    = 1;
    localparam int FRAME = (1 + PB + SB) * CPB;

    logic         clk = 1'b0;
    logic         resetn;
    logic         en;
    logic [7:0]   data;
    logic         txd;
    logic         busy;

    int total = 0;
    int bad   = 0;

    uart_tx #(
        .CYCLES_PER_BIT(CPB),
        .PAYLOAD_BITS  (PB),
        .STOP_BITS     (SB),
        .COUNT_REG_LEN (4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .uart_tx_en  (en),
        .uart_tx_data(data),
        .uart_txd    (txd),
        .uart_tx_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame timing arithmetic) ----------
    logic [7:0] exp_q[$];
    bit         m_active  = 1'b0;
    int         m_elapsed = 0;
    logic [7:0] m_data    = '0;
    int         m_done    = 0;
    bit         chk_on    = 1'b0;

    function automatic logic line_level(input int el, input logic [7:0] d);
        int idx;
        idx = el / CPB;
        if (idx == 0)       return 1'b0;
        else if (idx <= PB) return d[idx-1];
        else                return 1'b1;
    endfunction

    always @(posedge clk) begin
        chk_on = 1'b1;
        if (!resetn) begin
            m_active = 1'b0;
            exp_q.delete();
        end else if (m_active) begin
            m_elapsed++;
            if (m_elapsed == FRAME) begin
                m_active = 1'b0;
                m_done++;
            end
        end else if (en) begin
            m_active  = 1'b1;
            m_elapsed = 0;
            m_data    = data;
            exp_q.push_back(data);
        end
    end

    // ---------------- monitor: per-cycle line check + receiver ----------
    bit         in_rx = 1'b0;
    int         rx_cnt = 0;
    logic [9:0] rx_bits;
    logic [7:0] rx_exp;
    bit         rx_has_exp;
    int         rx_frames = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", {31'b0, busy}, {31'b0, m_active});
            chk("txd", {31'b0, txd}, {31'b0, m_active ? line_level(m_elapsed, m_data) : 1'b1});
        end
        if (!resetn) begin
            in_rx = 1'b0;
        end else if (!in_rx) begin
            if (txd === 1'b0) begin
                in_rx  = 1'b1;
                rx_cnt = 0;
                rx_bits = '1;
                if (exp_q.size() == 0) begin
                    rx_has_exp = 1'b0;
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got start bit want idle at %0t", $time);
                end else begin
                    rx_has_exp = 1'b1;
                    rx_exp = exp_q.pop_front();
                end
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                rx_bits[rx_cnt / CPB] = txd;
                if (rx_cnt / CPB == PB + 1) begin
                    in_rx = 1'b0;
                    rx_frames++;
                    chk("start_bit", {31'b0, rx_bits[0]}, 32'd0);
                    chk("stop_bit", {31'b0, rx_bits[PB+1]}, 32'd1);
                    if (rx_has_exp)
                        chk("rx_data", {24'b0, rx_bits[PB:1]}, {24'b0, rx_exp});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_pulse(input logic [7:0] d);
        en   = 1'b1;
        data = d;
        cyc(1);
        en   = 1'b0;
        data = 8'($urandom);
    endtask

    logic [7:0] loop_bytes [4];

    initial begin
        resetn = 1'b0;
        en     = 1'b0;
        data   = '0;
        cyc(3);
        resetn = 1'b1;
        cyc(100);

        send_pulse(8'hA5);
        cyc(45);

        send_pulse(8'h00);
        cyc(9);
        en = 1'b1; data = 8'hFF;
        cyc(1);
        en = 1'b0;
        cyc(50);

        en = 1'b1; data = 8'h55;
        cyc(1);
        data = 8'hC3;
        cyc(60);
        en = 1'b0;
        cyc(50);

        send_pulse(8'h0F);
        cyc(15);
        resetn = 1'b0;
        cyc(1);
        resetn = 1'b1;
        cyc(3);
        send_pulse(8'h0F);
        cyc(45);

        loop_bytes[0] = 8'h00;
        loop_bytes[1] = 8'h7E;
        loop_bytes[2] = 8'hAB;
        loop_bytes[3] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            send_pulse(loop_bytes[i]);
            cyc(42);
        end

        for (int i = 0; i < 3000; i++) begin
            en     = ($urandom_range(0, 7) == 0);
            data   = 8'($urandom);
            resetn = !(($urandom_range(0, 299) == 0) &&
                       !(m_active && m_elapsed >= FRAME - 4));
            cyc(1);
        end
        en     = 1'b0;
        resetn = 1'b1;
        cyc(60);

        chk("queue_empty", exp_q.size(), 32'd0);
        chk("frame_count", rx_frames, m_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
